// File: rtl/controle_inimigos_if.sv
// Control and rendering bus of the enemy-formation sequencer.
// The game side (master) drives the commands; the sequencer (slave) drives the renderer-facing state.
interface controle_inimigos_if;
  logic        frame_tick;
  logic        start;
  logic        pausa;
  logic        hit_valid;
  logic [2:0]  hit_idx;
  logic [49:0] inimigo_x;
  logic [49:0] inimigo_y;
  logic [0:4]  inimigo_vivo_array;
  logic        onda_limpa;
  logic        chegou_base;
  logic [2:0]  estado;

  modport master (
    output frame_tick, start, pausa, hit_valid, hit_idx,
    input  inimigo_x, inimigo_y, inimigo_vivo_array, onda_limpa, chegou_base, estado
  );

  modport slave (
    input  frame_tick, start, pausa, hit_valid, hit_idx,
    output inimigo_x, inimigo_y, inimigo_vivo_array, onda_limpa, chegou_base, estado
  );
endinterface

// File: rtl/controle_inimigos.sv
// Five-enemy formation sequencer: marches the rigid formation on frame ticks, descends and
// reverses at the walls, tracks kills, and flags wave clear or invasion.
module controle_inimigos #(
  parameter int unsigned X_INICIAL   = 40,
  parameter int unsigned Y_INICIAL   = 40,
  parameter int unsigned ESPACAMENTO = 100,
  parameter int unsigned PASSO_X     = 4,
  parameter int unsigned PASSO_Y     = 16,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 600,
  parameter int unsigned Y_LIMITE    = 400,
  parameter int unsigned DIVISOR     = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  controle_inimigos_if.slave   bus
);

  localparam int unsigned N     = 5;
  localparam int unsigned CW    = 10;
  localparam int unsigned EW    = CW + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCHA  = 3'd1,
    DESCE   = 3'd2,
    VITORIA = 3'd3,
    INVASAO = 3'd4
  } estado_t;

  estado_t           r_state, w_nxt;
  logic [CW-1:0]     r_x [N];
  logic [CW-1:0]     r_y [N];
  logic [0:N-1]      r_vivo;
  logic              r_dir_esq;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_onda;
  logic              r_base;

  logic              w_load, w_move, w_desce, w_cnt_inc, w_cnt_clr, w_kill, w_tick;
  logic              w_bate, w_invade;
  logic [CW-1:0]     w_max_x, w_min_x;

  function automatic logic [CW-1:0] x_inicial(input int unsigned idx);
    return CW'(X_INICIAL + idx * ESPACAMENTO);
  endfunction

  // Wall and base-line tests look only at living enemies, using pre-hit vivo
  always_comb begin
    w_max_x  = '0;
    w_min_x  = '1;
    w_invade = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_vivo[i]) begin
        if (r_x[i] > w_max_x) w_max_x = r_x[i];
        if (r_x[i] < w_min_x) w_min_x = r_x[i];
        if ((EW'(r_y[i]) + EW'(PASSO_Y)) >= EW'(Y_LIMITE)) w_invade = 1'b1;
      end
    end
    w_bate = r_dir_esq ? (EW'(w_min_x) < EW'(X_MIN + PASSO_X))
                       : ((EW'(w_max_x) + EW'(PASSO_X)) > EW'(X_MAX));
  end

  // Next-state and datapath controls
  always_comb begin
    w_nxt     = r_state;
    w_load    = 1'b0;
    w_move    = 1'b0;
    w_desce   = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    w_tick    = bus.frame_tick && !bus.pausa;
    w_kill    = bus.hit_valid && (bus.hit_idx <= 3'd4) &&
                ((r_state == MARCHA) || (r_state == DESCE));
    case (r_state)
      IDLE, VITORIA, INVASAO: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_nxt  = MARCHA;
        end
      end
      MARCHA: begin
        if (r_vivo == '0) begin
          w_nxt = VITORIA;
        end else if (w_tick) begin
          if (r_cnt == CNT_W'(DIVISOR - 1)) begin
            w_cnt_clr = 1'b1;
            if (w_bate) w_nxt  = DESCE;
            else        w_move = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      DESCE: begin
        if (r_vivo == '0) begin
          w_nxt = VITORIA;
        end else begin
          w_desce = 1'b1;
          w_nxt   = w_invade ? INVASAO : MARCHA;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_onda  <= 1'b0;
      r_base  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_onda  <= (w_nxt == VITORIA);
      r_base  <= (w_nxt == INVASAO);
    end
  end

  // Formation datapath: all five enemies move together, dead ones included
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= x_inicial(i);
        r_y[i] <= CW'(Y_INICIAL);
      end
      r_vivo    <= '0;
      r_dir_esq <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= x_inicial(i);
        r_y[i] <= CW'(Y_INICIAL);
      end
      r_vivo    <= '1;
      r_dir_esq <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_move) begin
        for (int i = 0; i < N; i++)
          r_x[i] <= r_dir_esq ? (r_x[i] - CW'(PASSO_X)) : (r_x[i] + CW'(PASSO_X));
      end
      if (w_desce) begin
        for (int i = 0; i < N; i++) r_y[i] <= r_y[i] + CW'(PASSO_Y);
        r_dir_esq <= ~r_dir_esq;
      end
      if (w_kill) r_vivo[bus.hit_idx] <= 1'b0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.inimigo_x[CW*g +: CW] = r_x[g];
    assign bus.inimigo_y[CW*g +: CW] = r_y[g];
  end

  assign bus.inimigo_vivo_array = r_vivo;
  assign bus.onda_limpa         = r_onda;
  assign bus.chegou_base        = r_base;
  assign bus.estado             = r_state;

endmodule

// File: tb/tb_controle_inimigos.sv
// Directed bench for controle_inimigos: a default instance plus one with a low base line.
module tb_controle_inimigos;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nd;
  exp_t q[$];

  always #5 clk = ~clk;

  controle_inimigos_if b1();
  controle_inimigos_if b2();

  controle_inimigos u1 (.CLOCK_50(clk), .reset(rst1), .bus(b1));
  controle_inimigos #(.Y_LIMITE(72), .DIVISOR(1)) u2 (.CLOCK_50(clk), .reset(rst2), .bus(b2));

  function automatic logic [49:0] pk(input int base, input int sp);
    logic [49:0] r;
    for (int i = 0; i < 5; i++) r[10*i +: 10] = 10'(base + i*sp);
    return r;
  endfunction

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h with no expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks1(input int n);
    repeat (n) begin
      b1.frame_tick = 1'b1;
      step();
    end
    b1.frame_tick = 1'b0;
  endtask

  task automatic hit1(input int idx);
    b1.hit_valid = 1'b1;
    b1.hit_idx   = 3'(idx);
    step();
    b1.hit_valid = 1'b0;
  endtask

  task automatic start1();
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {b1.frame_tick, b1.start, b1.pausa, b1.hit_valid} = '0;
    {b2.frame_tick, b2.start, b2.pausa, b2.hit_valid} = '0;
    b1.hit_idx = '0;
    b2.hit_idx = '0;

    // Reset state
    push("rst_estado", 0); push("rst_vivo", 0); push("rst_x", pk(40, 100));
    push("rst_y", pk(40, 0)); push("rst_onda", 0); push("rst_base", 0);
    rst1 = 1'b0; rst2 = 1'b0;
    step(); step();
    chk(b1.estado); chk(b1.inimigo_vivo_array); chk(b1.inimigo_x);
    chk(b1.inimigo_y); chk(b1.onda_limpa); chk(b1.chegou_base);

    // Start loads the wave
    rst1 = 1'b1; step();
    push("start_estado", 1); push("start_x", pk(40, 100));
    push("start_y", pk(40, 0)); push("start_vivo", 5'b11111);
    start1();
    chk(b1.estado); chk(b1.inimigo_x); chk(b1.inimigo_y); chk(b1.inimigo_vivo_array);

    // March to the right wall, descend, turn left
    push("x4_600", 600); push("estado_marcha", 1);
    ticks1(160);
    chk(b1.inimigo_x[49:40]); chk(b1.estado);
    push("estado_desce", 2);
    ticks1(4);
    chk(b1.estado);
    push("pos_desce_estado", 1); push("y_56", pk(56, 0));
    step();
    chk(b1.estado); chk(b1.inimigo_y);
    push("x4_596", 596);
    ticks1(4);
    chk(b1.inimigo_x[49:40]);

    // Pause freezes counter and x but not kills
    push("pausa_x", pk(196, 100)); push("pausa_vivo", 5'b10111);
    b1.pausa = 1'b1;
    ticks1(5); hit1(1); ticks1(5);
    b1.pausa = 1'b0;
    chk(b1.inimigo_x); chk(b1.inimigo_vivo_array);
    push("cnt_kept", pk(196, 100));
    ticks1(3);
    chk(b1.inimigo_x);
    push("pos_pausa", pk(192, 100));
    ticks1(1);
    chk(b1.inimigo_x);
    push("start_ignored_x", pk(192, 100)); push("start_ignored_vivo", 5'b10111);
    start1();
    chk(b1.inimigo_x); chk(b1.inimigo_vivo_array);

    // Dead enemies are excluded from the wall test
    rst1 = 1'b0; step(); rst1 = 1'b1; step();
    start1();
    push("kill43_vivo", 5'b11100);
    hit1(4); hit1(3);
    chk(b1.inimigo_vivo_array);
    push("t363_x2", 600); push("t363_x4", 800); push("t363_estado", 1);
    ticks1(363);
    chk(b1.inimigo_x[29:20]); chk(b1.inimigo_x[49:40]); chk(b1.estado);
    push("t364_estado", 2);
    ticks1(1);
    chk(b1.estado);
    step();

    // Kill the rest, with an out-of-range index interleaved
    b1.hit_valid = 1'b1;
    push("k0", 5'b01100); b1.hit_idx = 3'd0; step(); chk(b1.inimigo_vivo_array);
    push("k6", 5'b01100); b1.hit_idx = 3'd6; step(); chk(b1.inimigo_vivo_array);
    push("k1", 5'b00100); b1.hit_idx = 3'd1; step(); chk(b1.inimigo_vivo_array);
    push("k2_vivo", 0); push("k2_onda", 0);
    b1.hit_idx = 3'd2; step();
    b1.hit_valid = 1'b0;
    chk(b1.inimigo_vivo_array); chk(b1.onda_limpa);
    push("onda_limpa", 1); push("vitoria", 3);
    step();
    chk(b1.onda_limpa); chk(b1.estado);
    push("vitoria_frozen", 3); push("vitoria_vivo", 0);
    ticks1(8);
    chk(b1.estado); chk(b1.inimigo_vivo_array);
    push("reload_estado", 1); push("reload_vivo", 5'b11111);
    push("reload_x", pk(40, 100)); push("reload_onda", 0);
    start1();
    chk(b1.estado); chk(b1.inimigo_vivo_array); chk(b1.inimigo_x); chk(b1.onda_limpa);

    // Second instance: asynchronous reset in DESCE
    rst2 = 1'b1; step();
    b2.start = 1'b1; step(); b2.start = 1'b0;
    b2.frame_tick = 1'b1;
    for (int c = 0; c < 200 && b2.estado != 3'd2; c++) step();
    push("reached_desce", 2);
    chk(b2.estado);
    push("rst_mid_estado", 0); push("rst_mid_x", pk(40, 100));
    push("rst_mid_y", pk(40, 0)); push("rst_mid_vivo", 0);
    rst2 = 1'b0;
    #1;
    chk(b2.estado); chk(b2.inimigo_x); chk(b2.inimigo_y); chk(b2.inimigo_vivo_array);
    b2.frame_tick = 1'b0;
    rst2 = 1'b1; step();

    // Invasion after the second descent
    b2.start = 1'b1; step(); b2.start = 1'b0;
    b2.frame_tick = 1'b1;
    nd = 0;
    for (int c = 0; c < 1000 && b2.estado != 3'd4; c++) begin
      step();
      if (b2.estado == 3'd2) nd++;
    end
    push("descidas", 2); push("inv_estado", 4); push("inv_base", 1);
    push("inv_y", pk(72, 0)); push("inv_x", pk(0, 100));
    chk(nd); chk(b2.estado); chk(b2.chegou_base); chk(b2.inimigo_y); chk(b2.inimigo_x);
    push("frozen_x", pk(0, 100)); push("frozen_y", pk(72, 0)); push("frozen_estado", 4);
    repeat (20) step();
    chk(b2.inimigo_x); chk(b2.inimigo_y); chk(b2.estado);
    b2.frame_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
